// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with latch-time WB bypass, operand forwarding and hazard stall.
// Optional macro ID_EX_FORWARD_EN: MEM/WB forwarding muxes with load-use-only stall;
// when undefined, operands come straight from the latch and any RAW hazard stalls.
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int RADDR = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [3:0]       id_ALUCode,
  input  logic [RADDR-1:0] id_rs1_addr,
  input  logic [RADDR-1:0] id_rs2_addr,
  input  logic [RADDR-1:0] id_rd_addr,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic             id_ALUSrcB,
  input  logic             id_RegWrite,
  input  logic             id_MemRead,
  input  logic             id_MemWrite,
  input  logic             flush,
  input  logic             mem_RegWrite,
  input  logic [RADDR-1:0] mem_rd_addr,
  input  logic [XLEN-1:0]  mem_ALUResult,
  input  logic             wb_RegWrite,
  input  logic [RADDR-1:0] wb_rd_addr,
  input  logic [XLEN-1:0]  wb_data,
  output logic             ex_valid,
  output logic [3:0]       ex_ALUCode,
  output logic [XLEN-1:0]  ex_A,
  output logic [XLEN-1:0]  ex_B,
  output logic [XLEN-1:0]  ex_store_data,
  output logic [RADDR-1:0] ex_rd_addr,
  output logic             ex_RegWrite,
  output logic             ex_MemRead,
  output logic             ex_MemWrite,
  output logic             stall
);

  logic             valid_q, valid_d;
  logic [3:0]       alu_q, alu_d;
  logic [RADDR-1:0] rd_q, rd_d;
  logic [XLEN-1:0]  rs1_data_q, rs1_data_d;
  logic [XLEN-1:0]  rs2_data_q, rs2_data_d;
  logic [XLEN-1:0]  imm_q, imm_d;
  logic             srcb_q, srcb_d;
  logic             regw_q, regw_d;
  logic             memr_q, memr_d;
  logic             memw_q, memw_d;
`ifdef ID_EX_FORWARD_EN
  logic [RADDR-1:0] rs1_q, rs1_d;
  logic [RADDR-1:0] rs2_q, rs2_d;
`endif

  logic            bubble, hazard;
  logic            wb_hit1, wb_hit2;
  logic [XLEN-1:0] fwd1, fwd2;

  assign bubble  = flush | stall;
  // The register file write and this read happen in the same cycle, so pick up WB here.
  assign wb_hit1 = wb_RegWrite && (wb_rd_addr == id_rs1_addr) && (id_rs1_addr != '0);
  assign wb_hit2 = wb_RegWrite && (wb_rd_addr == id_rs2_addr) && (id_rs2_addr != '0);

  always_comb begin
    valid_d    = 1'b0;
    alu_d      = '0;
    rd_d       = '0;
    rs1_data_d = '0;
    rs2_data_d = '0;
    imm_d      = '0;
    srcb_d     = 1'b0;
    regw_d     = 1'b0;
    memr_d     = 1'b0;
    memw_d     = 1'b0;
`ifdef ID_EX_FORWARD_EN
    rs1_d      = '0;
    rs2_d      = '0;
`endif
    if (!bubble) begin
      valid_d    = id_valid;
      alu_d      = id_ALUCode;
      rd_d       = id_rd_addr;
      rs1_data_d = wb_hit1 ? wb_data : id_rs1_data;
      rs2_data_d = wb_hit2 ? wb_data : id_rs2_data;
      imm_d      = id_imm;
      srcb_d     = id_ALUSrcB;
      regw_d     = id_RegWrite;
      memr_d     = id_MemRead;
      memw_d     = id_MemWrite;
`ifdef ID_EX_FORWARD_EN
      rs1_d      = id_rs1_addr;
      rs2_d      = id_rs2_addr;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q    <= 1'b0;
      alu_q      <= '0;
      rd_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      srcb_q     <= 1'b0;
      regw_q     <= 1'b0;
      memr_q     <= 1'b0;
      memw_q     <= 1'b0;
`ifdef ID_EX_FORWARD_EN
      rs1_q      <= '0;
      rs2_q      <= '0;
`endif
    end else begin
      valid_q    <= valid_d;
      alu_q      <= alu_d;
      rd_q       <= rd_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
      srcb_q     <= srcb_d;
      regw_q     <= regw_d;
      memr_q     <= memr_d;
      memw_q     <= memw_d;
`ifdef ID_EX_FORWARD_EN
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
`endif
    end
  end

`ifdef ID_EX_FORWARD_EN
  // MEM is younger than WB, so it wins; x0 always reads the latched zero.
  always_comb begin
    fwd1 = rs1_data_q;
    if (rs1_q != '0) begin
      if (mem_RegWrite && mem_rd_addr == rs1_q)     fwd1 = mem_ALUResult;
      else if (wb_RegWrite && wb_rd_addr == rs1_q)  fwd1 = wb_data;
    end
    fwd2 = rs2_data_q;
    if (rs2_q != '0) begin
      if (mem_RegWrite && mem_rd_addr == rs2_q)     fwd2 = mem_ALUResult;
      else if (wb_RegWrite && wb_rd_addr == rs2_q)  fwd2 = wb_data;
    end
  end

  assign hazard = valid_q && memr_q && (rd_q != '0) && id_valid &&
                  ((rd_q == id_rs1_addr) || (rd_q == id_rs2_addr));
`else
  logic ex_raw1, ex_raw2, mem_raw1, mem_raw2;
  logic unused_mem_result;

  assign fwd1 = rs1_data_q;
  assign fwd2 = rs2_data_q;
  assign unused_mem_result = ^mem_ALUResult;

  // Without forwarding, any producer still in EX or MEM blocks the reader in ID.
  assign ex_raw1  = valid_q && regw_q && (rd_q == id_rs1_addr);
  assign ex_raw2  = valid_q && regw_q && (rd_q == id_rs2_addr);
  assign mem_raw1 = mem_RegWrite && (mem_rd_addr == id_rs1_addr);
  assign mem_raw2 = mem_RegWrite && (mem_rd_addr == id_rs2_addr);
  assign hazard   = ((id_rs1_addr != '0) && (ex_raw1 || mem_raw1)) ||
                    ((id_rs2_addr != '0) && (ex_raw2 || mem_raw2));
`endif

  assign stall         = hazard & ~flush;
  assign ex_valid      = valid_q;
  assign ex_ALUCode    = alu_q;
  assign ex_A          = fwd1;
  assign ex_B          = srcb_q ? imm_q : fwd2;
  assign ex_store_data = fwd2;
  assign ex_rd_addr    = rd_q;
  assign ex_RegWrite   = regw_q;
  assign ex_MemRead    = memr_q;
  assign ex_MemWrite   = memw_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage; covers whichever ID_EX_FORWARD_EN build is compiled.
module tb_id_ex_stage;
  localparam int XLEN = 32, RADDR = 5;

  logic             clk = 1'b0, reset;
  logic             id_valid;
  logic [3:0]       id_ALUCode;
  logic [RADDR-1:0] id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic [XLEN-1:0]  id_rs1_data, id_rs2_data, id_imm;
  logic             id_ALUSrcB, id_RegWrite, id_MemRead, id_MemWrite;
  logic             flush;
  logic             mem_RegWrite;
  logic [RADDR-1:0] mem_rd_addr;
  logic [XLEN-1:0]  mem_ALUResult;
  logic             wb_RegWrite;
  logic [RADDR-1:0] wb_rd_addr;
  logic [XLEN-1:0]  wb_data;
  logic             ex_valid;
  logic [3:0]       ex_ALUCode;
  logic [XLEN-1:0]  ex_A, ex_B, ex_store_data;
  logic [RADDR-1:0] ex_rd_addr;
  logic             ex_RegWrite, ex_MemRead, ex_MemWrite, stall;

  int n_tests = 0, n_fail = 0;

  id_ex_stage #(.XLEN(XLEN), .RADDR(RADDR)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_ALUCode(id_ALUCode),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_ALUSrcB(id_ALUSrcB), .id_RegWrite(id_RegWrite), .id_MemRead(id_MemRead),
    .id_MemWrite(id_MemWrite), .flush(flush), .mem_RegWrite(mem_RegWrite),
    .mem_rd_addr(mem_rd_addr), .mem_ALUResult(mem_ALUResult), .wb_RegWrite(wb_RegWrite),
    .wb_rd_addr(wb_rd_addr), .wb_data(wb_data), .ex_valid(ex_valid), .ex_ALUCode(ex_ALUCode),
    .ex_A(ex_A), .ex_B(ex_B), .ex_store_data(ex_store_data), .ex_rd_addr(ex_rd_addr),
    .ex_RegWrite(ex_RegWrite), .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite),
    .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [3:0] alu, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [4:0] rd, input logic [31:0] d1,
                        input logic [31:0] d2, input logic [31:0] imm, input logic srcb,
                        input logic rw, input logic mr, input logic mw);
    id_valid = v; id_ALUCode = alu; id_rs1_addr = rs1; id_rs2_addr = rs2; id_rd_addr = rd;
    id_rs1_data = d1; id_rs2_data = d2; id_imm = imm; id_ALUSrcB = srcb;
    id_RegWrite = rw; id_MemRead = mr; id_MemWrite = mw;
  endtask

  task automatic idle_id();
    set_id(1'b0, 4'h0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic clr_fb();
    mem_RegWrite = 1'b0; mem_rd_addr = '0; mem_ALUResult = '0;
    wb_RegWrite = 1'b0; wb_rd_addr = '0; wb_data = '0;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0;
    idle_id(); clr_fb();
    #1;
    chk("rst_valid", 32'(ex_valid), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    tick(); tick();
    reset = 1'b0;

    // plain register-register op
    set_id(1'b1, 4'h3, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    idle_id();
    #1;
    chk("rr_valid", 32'(ex_valid), 32'd1);
    chk("rr_alu",   32'(ex_ALUCode), 32'h3);
    chk("rr_A",     ex_A, 32'd5);
    chk("rr_B",     ex_B, 32'd7);
    chk("rr_st",    ex_store_data, 32'd7);
    chk("rr_rd",    32'(ex_rd_addr), 32'd3);
    chk("rr_rw",    32'(ex_RegWrite), 32'd1);

    // store-like with immediate B; store data stays rs2
    tick();
    set_id(1'b1, 4'h0, 5'd4, 5'd9, 5'd7, 32'h10, 32'h99, 32'hFFFF_FFF0, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    idle_id();
    #1;
    chk("imm_A",  ex_A, 32'h10);
    chk("imm_B",  ex_B, 32'hFFFF_FFF0);
    chk("imm_st", ex_store_data, 32'h99);
    chk("imm_mw", 32'(ex_MemWrite), 32'd1);
    chk("imm_rw", 32'(ex_RegWrite), 32'd0);

    // latch-time WB bypass on rs1 only
    set_id(1'b1, 4'h1, 5'd8, 5'd6, 5'd10, 32'h11, 32'h22, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    wb_RegWrite = 1'b1; wb_rd_addr = 5'd8; wb_data = 32'hABCD;
    tick();
    clr_fb(); idle_id();
    #1;
    chk("byp_A",  ex_A, 32'hABCD);
    chk("byp_st", ex_store_data, 32'h22);

    // bypass disabled when WB not writing
    set_id(1'b1, 4'h1, 5'd8, 5'd0, 5'd10, 32'h11, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    wb_RegWrite = 1'b0; wb_rd_addr = 5'd8; wb_data = 32'hABCD;
    tick();
    clr_fb(); idle_id();
    #1;
    chk("nobyp_A", ex_A, 32'h11);

    // x0 never bypassed
    set_id(1'b1, 4'h1, 5'd0, 5'd0, 5'd10, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    wb_RegWrite = 1'b1; wb_rd_addr = 5'd0; wb_data = 32'h5555;
    tick();
    clr_fb(); idle_id();
    #1;
    chk("x0byp_A", ex_A, 32'h0);

    // flush turns a valid ID instruction into a zeroed bubble
    set_id(1'b1, 4'h7, 5'd1, 5'd2, 5'd12, 32'h44, 32'h55, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    flush = 1'b1;
    #1;
    chk("fl_stall", 32'(stall), 32'd0);
    tick();
    flush = 1'b0; idle_id();
    #1;
    chk("fl_valid", 32'(ex_valid), 32'd0);
    chk("fl_rw",    32'(ex_RegWrite), 32'd0);
    chk("fl_alu",   32'(ex_ALUCode), 32'd0);
    chk("fl_A",     ex_A, 32'd0);
    chk("fl_rd",    32'(ex_rd_addr), 32'd0);

`ifdef ID_EX_FORWARD_EN
    set_id(1'b1, 4'h0, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    idle_id();
    mem_RegWrite = 1'b1; mem_rd_addr = 5'd1; mem_ALUResult = 32'h100;
    #1;
    chk("fmem_A", ex_A, 32'h100);
    chk("fmem_B", ex_B, 32'd7);
    wb_RegWrite = 1'b1; wb_rd_addr = 5'd1; wb_data = 32'h200;
    #1;
    chk("fprio_A", ex_A, 32'h100);
    mem_RegWrite = 1'b0;
    #1;
    chk("fwb_A", ex_A, 32'h200);
    wb_rd_addr = 5'd2;
    #1;
    chk("fwb_B",  ex_B, 32'h200);
    chk("fwb_st", ex_store_data, 32'h200);
    chk("fwb_A5", ex_A, 32'd5);
    clr_fb();

    // x0 guard on the forward path
    set_id(1'b1, 4'h0, 5'd0, 5'd2, 5'd3, 32'h0, 32'd7, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    idle_id();
    mem_RegWrite = 1'b1; mem_rd_addr = 5'd0; mem_ALUResult = 32'h100;
    #1;
    chk("fx0_A", ex_A, 32'h0);
    clr_fb();

    // load-use: lw x5 in EX, add x6,x5,x1 in ID
    set_id(1'b1, 4'h0, 5'd1, 5'd0, 5'd5, 32'h1000, 32'h0, 32'd4, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 4'h0, 5'd5, 5'd1, 5'd6, 32'h0, 32'd9, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    chk("lu_stall", 32'(stall), 32'd1);
    tick();
    mem_RegWrite = 1'b1; mem_rd_addr = 5'd5; mem_ALUResult = 32'h1004;
    #1;
    chk("lu_bub",    32'(ex_valid), 32'd0);
    chk("lu_stall2", 32'(stall), 32'd0);
    tick();
    idle_id(); clr_fb();
    wb_RegWrite = 1'b1; wb_rd_addr = 5'd5; wb_data = 32'hDEAD;
    #1;
    chk("lu_valid", 32'(ex_valid), 32'd1);
    chk("lu_A",     ex_A, 32'hDEAD);
    chk("lu_B",     ex_B, 32'd9);
    clr_fb();

    // load-use coinciding with flush
    set_id(1'b1, 4'h0, 5'd1, 5'd0, 5'd5, 32'h1000, 32'h0, 32'd4, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 4'h0, 5'd5, 5'd1, 5'd6, 32'h0, 32'd9, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    flush = 1'b1;
    #1;
    chk("luf_stall", 32'(stall), 32'd0);
    tick();
    flush = 1'b0; idle_id();
    #1;
    chk("luf_valid", 32'(ex_valid), 32'd0);
    chk("luf_rw",    32'(ex_RegWrite), 32'd0);
`else
    // no forwarding: MEM result must not reach the operand
    set_id(1'b1, 4'h0, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    idle_id();
    mem_RegWrite = 1'b1; mem_rd_addr = 5'd1; mem_ALUResult = 32'h100;
    #1;
    chk("nf_A", ex_A, 32'd5);
    clr_fb();

    // RAW: add x3 in EX, add x4,x3,x3 in ID -> two stalls then WB bypass
    set_id(1'b1, 4'h0, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    set_id(1'b1, 4'h0, 5'd3, 5'd3, 5'd4, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    chk("raw_st1", 32'(stall), 32'd1);
    tick();
    mem_RegWrite = 1'b1; mem_rd_addr = 5'd3; mem_ALUResult = 32'h333;
    #1;
    chk("raw_bub1", 32'(ex_valid), 32'd0);
    chk("raw_st2",  32'(stall), 32'd1);
    tick();
    clr_fb();
    wb_RegWrite = 1'b1; wb_rd_addr = 5'd3; wb_data = 32'h333;
    #1;
    chk("raw_bub2", 32'(ex_valid), 32'd0);
    chk("raw_st3",  32'(stall), 32'd0);
    tick();
    clr_fb(); idle_id();
    #1;
    chk("raw_valid", 32'(ex_valid), 32'd1);
    chk("raw_A",     ex_A, 32'h333);
    chk("raw_B",     ex_B, 32'h333);
    chk("raw_rd",    32'(ex_rd_addr), 32'd4);

    // RAW coinciding with flush
    set_id(1'b1, 4'h0, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    set_id(1'b1, 4'h0, 5'd3, 5'd3, 5'd4, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    flush = 1'b1;
    #1;
    chk("rawf_stall", 32'(stall), 32'd0);
    tick();
    flush = 1'b0; idle_id();
    #1;
    chk("rawf_valid", 32'(ex_valid), 32'd0);
`endif

    // asynchronous reset mid-run
    set_id(1'b1, 4'h5, 5'd1, 5'd2, 5'd9, 32'h77, 32'h88, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    idle_id();
    #1;
    chk("pre_rst_valid", 32'(ex_valid), 32'd1);
    reset = 1'b1;
    #1;
    chk("arst_valid", 32'(ex_valid), 32'd0);
    chk("arst_alu",   32'(ex_ALUCode), 32'd0);
    chk("arst_A",     ex_A, 32'd0);
    chk("arst_rw",    32'(ex_RegWrite), 32'd0);
    chk("arst_stall", 32'(stall), 32'd0);
    tick();
    reset = 1'b0;
    set_id(1'b1, 4'h2, 5'd1, 5'd2, 5'd11, 32'h12, 32'h34, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    idle_id();
    #1;
    chk("post_rst_A", ex_A, 32'h12);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
